// File: rtl/sample_collect_if.sv
// Handshake bundle between the sample stage, the hit collector and the z-buffer.
// The collector consumes lane bundles on the in_* side and emits single hits on the out_* side.
interface sample_collect_if #(
  parameter int SIGFIG = 24,
  parameter int COLORS = 3,
  parameter int SAMPS  = 8
);
  localparam int LW = (SAMPS > 1) ? $clog2(SAMPS) : 1;

  logic                     in_valid;
  logic                     in_ready;
  logic [SAMPS-1:0]         in_hit;
  logic [SAMPS*SIGFIG-1:0]  in_x;
  logic [SAMPS*SIGFIG-1:0]  in_y;
  logic [COLORS*SIGFIG-1:0] in_color;

  logic                     out_valid;
  logic                     out_ready;
  logic [SIGFIG-1:0]        out_x;
  logic [SIGFIG-1:0]        out_y;
  logic [COLORS*SIGFIG-1:0] out_color;
  logic [LW-1:0]            out_lane;
  logic [15:0]              hit_count;

  // Upstream sample stage and downstream z-buffer, seen together as one master.
  modport master (
    output in_valid, in_hit, in_x, in_y, in_color, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_color, out_lane, hit_count
  );

  modport slave (
    input  in_valid, in_hit, in_x, in_y, in_color, out_ready,
    output in_ready, out_valid, out_x, out_y, out_color, out_lane, hit_count
  );
endinterface

// File: rtl/sample_collect.sv
// Serialises a bundle of per-lane sample hits into one hit per cycle, lowest lane first,
// with a zero-bubble handover from the last hit of one bundle to the first of the next.
module sample_collect #(
  parameter int SIGFIG = 24,
  parameter int COLORS = 3,
  parameter int SAMPS  = 8,
  localparam int LW    = (SAMPS > 1) ? $clog2(SAMPS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  sample_collect_if.slave  bus
);

  typedef enum logic {S_EMPTY, S_DRAIN} state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [SAMPS-1:0]         r_pend;
  logic [SAMPS*SIGFIG-1:0]  r_x_lat;
  logic [SAMPS*SIGFIG-1:0]  r_y_lat;
  logic [SIGFIG-1:0]        r_out_x;
  logic [SIGFIG-1:0]        r_out_y;
  logic [COLORS*SIGFIG-1:0] r_out_color;
  logic [LW-1:0]            r_out_lane;
  logic [15:0]              r_hit_count;

  logic                     w_in_ready;
  logic                     w_in_fire;
  logic                     w_out_fire;
  logic                     w_load_new;
  logic                     w_load_pend;
  logic [LW-1:0]            w_new_lane;
  logic [LW-1:0]            w_pend_lane;
  logic [SIGFIG-1:0]        w_in_x   [SAMPS];
  logic [SIGFIG-1:0]        w_in_y   [SAMPS];
  logic [SIGFIG-1:0]        w_lat_x  [SAMPS];
  logic [SIGFIG-1:0]        w_lat_y  [SAMPS];

  function automatic logic [LW-1:0] lowest_lane(input logic [SAMPS-1:0] mask);
    lowest_lane = '0;
    for (int i = SAMPS - 1; i >= 0; i--) begin
      if (mask[i]) lowest_lane = LW'(i);
    end
  endfunction

  for (genvar gi = 0; gi < SAMPS; gi++) begin : g_lanes
    assign w_in_x[gi]  = bus.in_x[gi*SIGFIG +: SIGFIG];
    assign w_in_y[gi]  = bus.in_y[gi*SIGFIG +: SIGFIG];
    assign w_lat_x[gi] = r_x_lat[gi*SIGFIG +: SIGFIG];
    assign w_lat_y[gi] = r_y_lat[gi*SIGFIG +: SIGFIG];
  end

  // A new bundle is only taken while the last pending hit leaves, so draining never stalls.
  assign w_in_ready  = !rst && ((r_state == S_EMPTY) || (bus.out_ready && (r_pend == '0)));
  assign w_in_fire   = bus.in_valid && w_in_ready;
  assign w_out_fire  = (r_state == S_DRAIN) && bus.out_ready;
  assign w_load_new  = w_in_fire && (bus.in_hit != '0);
  assign w_new_lane  = lowest_lane(bus.in_hit);
  assign w_pend_lane = lowest_lane(r_pend);

  always_comb begin
    w_state_next = r_state;
    w_load_pend  = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_load_new) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_out_fire) begin
          if (r_pend != '0)     w_load_pend  = 1'b1;
          else if (!w_load_new) w_state_next = S_EMPTY;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= '0;
      r_x_lat     <= '0;
      r_y_lat     <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_color <= '0;
      r_out_lane  <= '0;
      r_hit_count <= '0;
    end else begin
      if (w_out_fire) r_hit_count <= r_hit_count + 16'd1;
      // x & (x-1) clears the lowest set bit, i.e. the lane being presented.
      if (w_load_new) begin
        r_pend      <= bus.in_hit & (bus.in_hit - SAMPS'(1));
        r_x_lat     <= bus.in_x;
        r_y_lat     <= bus.in_y;
        r_out_color <= bus.in_color;
        r_out_lane  <= w_new_lane;
        r_out_x     <= w_in_x[w_new_lane];
        r_out_y     <= w_in_y[w_new_lane];
      end else if (w_load_pend) begin
        r_pend      <= r_pend & (r_pend - SAMPS'(1));
        r_out_lane  <= w_pend_lane;
        r_out_x     <= w_lat_x[w_pend_lane];
        r_out_y     <= w_lat_y[w_pend_lane];
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DRAIN);
  assign bus.out_x     = r_out_x;
  assign bus.out_y     = r_out_y;
  assign bus.out_color = r_out_color;
  assign bus.out_lane  = r_out_lane;
  assign bus.hit_count = r_hit_count;

endmodule

// File: doc/sample_collect.md
SAMPLE_COLLECT -- requirements
Module: sample_collect

Interface
REQ-001 SHALL have parameter SIGFIG, default 24, meaning bits per position/color field.
REQ-002 SHALL have parameter COLORS, default 3, meaning color channels per hit.
REQ-003 SHALL have parameter SAMPS, default 8, meaning parallel sample lanes per input bundle; LW = $clog2(SAMPS).
REQ-004 SHALL have port clk  input  1  clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  bundle from sample stage valid.
REQ-007 SHALL have port in_ready  output  1  collector accepts bundle this cycle.
REQ-008 SHALL have port in_hit  input  SAMPS  per-lane hit mask.
REQ-009 SHALL have port in_x  input  SAMPS*SIGFIG  per-lane sample x, lane i at [i*SIGFIG +: SIGFIG].
REQ-010 SHALL have port in_y  input  SAMPS*SIGFIG  per-lane sample y, same packing.
REQ-011 SHALL have port in_color  input  COLORS*SIGFIG  triangle color shared by all lanes.
REQ-012 SHALL have port out_valid  output  1  one hit presented to z-buffer.
REQ-013 SHALL have port out_ready  input  1  z-buffer accepts hit.
REQ-014 SHALL have ports out_x, out_y  output  SIGFIG each  hit sample position.
REQ-015 SHALL have port out_color  output  COLORS*SIGFIG  hit color.
REQ-016 SHALL have port out_lane  output  LW  source lane index of hit.
REQ-017 SHALL have port hit_count  output  16  hits delivered since reset.

Function
REQ-018 Input fire = in_valid && in_ready; output fire = out_valid && out_ready.
REQ-019 State: pending mask register P (SAMPS bits) plus latched bundle (x, y, color); two states EMPTY (out_valid=0) and DRAIN (out_valid=1).
REQ-020 in_ready SHALL be combinational: 1 when EMPTY, or when DRAIN && out_ready && P==0; otherwise 0.
REQ-021 On input fire with in_hit!=0: next cycle DRAIN, out_* = lowest set lane L of in_hit, P = in_hit with bit L cleared; latency exactly 1 cycle.
REQ-022 On input fire with in_hit==0: bundle dropped, next cycle EMPTY, no output produced.
REQ-023 In DRAIN with output fire and P!=0: next cycle present lowest set lane of P from latched bundle, clear that bit; one hit per cycle.
REQ-024 In DRAIN with output fire, P==0 and no input fire: next cycle EMPTY.
REQ-025 Output fire and input fire in same cycle (REQ-020 last hit) SHALL hand over with no bubble: new bundle's first hit valid next cycle.
REQ-026 While out_valid && !out_ready, all out_* and P SHALL hold stable.
REQ-027 Lanes SHALL be emitted in strictly ascending index order; each set lane exactly once.
REQ-028 hit_count increments by 1 on each output fire, wraps 0xFFFF -> 0x0000.
REQ-029 out_* SHALL be driven from registers only (no combinational input-to-output data path).

Reset
REQ-030 rst=1 on clock edge: state EMPTY, out_valid=0, P=0, hit_count=0, out_x/out_y/out_color/out_lane=0.
REQ-031 rst asserted mid-DRAIN SHALL discard all pending lanes; no further hits from that bundle after reset deassert.
REQ-032 in_ready SHALL be 0 in any cycle rst=1.

Verification
REQ-033 Mask 8'b1010_0101, out_ready=1 -> out_lane 0,2,5,7 on cycles N+1..N+4, in_ready=1 only in cycle N+4, hit_count=4.
REQ-034 Mask 8'h00 accepted -> no out_valid, in_ready stays 1, hit_count unchanged.
REQ-035 Mask 8'h01 then 8'h80 back-to-back, out_ready=1 -> lane 0 at N+1, lane 7 at N+2, no bubble.
REQ-036 Mask 8'hFF, out_ready toggling 1,0,1,0 -> 8 hits, each held stable while stalled, x/y match lane inputs, color identical on all.
REQ-037 Mask 8'hFF, rst pulsed after 3rd hit -> out_valid=0 next cycle, hit_count=0, no lanes 3..7 emitted.
REQ-038 Preload 65535 hits via streaming, one more hit -> hit_count=0x0000.
